iicmb_wb_sequencer: RTL
=======================

IICMB_WB_SEQUENCER -- requirements
Module: iicmb_wb_sequencer

Interface
REQ-001 SHALL have parameter BUS_ID, default 0: I2C bus number written to DPR during the set-bus step.
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 2: width of the Wishbone register address.
REQ-003 SHALL have parameter WB_DATA_WIDTH, default 8: width of the Wishbone data path.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic is posedge clk_i.
REQ-005 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid_i, input, 1 bit: a transaction request is present.
REQ-007 SHALL have port req_ready_o, output, 1 bit: sequencer accepts a request.
REQ-008 SHALL have port req_rw_i, input, 1 bit: 0 = I2C write, 1 = I2C read.
REQ-009 SHALL have port req_addr_i, input, 7 bits: I2C slave address.
REQ-010 SHALL have port req_len_i, input, 6 bits: byte count; legal range 1..32.
REQ-011 SHALL have ports wr_valid_i (input, 1), wr_ready_o (output, 1) and wr_data_i (input, 8): write-byte stream.
REQ-012 SHALL have ports rd_valid_o (output, 1) and rd_data_o (output, 8): read-byte stream, no backpressure.
REQ-013 SHALL have ports done_o (output, 1) and err_o (output, 2): end-of-transaction pulse and status (00 ok, 01 NAK, 10 arbitration lost, 11 ERR or illegal length).
REQ-014 SHALL have ports cyc_o, stb_o, we_o (outputs, 1 each), adr_o (output, WB_ADDR_WIDTH), dat_o (output, WB_DATA_WIDTH): Wishbone master outputs.
REQ-015 SHALL have ports dat_i (input, WB_DATA_WIDTH), ack_i (input, 1), irq_i (input, 1): Wishbone master inputs and the IICMB interrupt.

Function
REQ-016 SHALL address registers CSR=0, DPR=1, CMDR=2.
REQ-017 SHALL use command codes START 0x04, WRITE 0x01, READ_ACK 0x02, READ_NAK 0x03, STOP 0x05, SET_BUS 0x06.
REQ-018 SHALL treat CMDR status bits as DON[7], NAK[6], AL[5], ERR[4].
REQ-019 Wishbone cycle: SHALL hold cyc_o, stb_o, we_o, adr_o and dat_o stable from issue until ack_i is sampled high.
REQ-020 Wishbone cycle: SHALL deassert cyc_o and stb_o the following cycle and keep at least 1 idle cycle between accesses.
REQ-021 On a read access, SHALL capture dat_i on the ack_i cycle.
REQ-022 Command step: SHALL write CMDR, wait for irq_i=1 (level, no timeout), then read CMDR, which clears irq; status is decoded from that read.
REQ-023 INIT states, entered after reset: EN (write CSR 0xC0) -> SETBUS (write DPR BUS_ID, command step SET_BUS) -> IDLE.
REQ-024 If SETBUS returns ERR, SHALL stay in ERR_HALT with err_o=11 until reset.
REQ-025 IDLE: SHALL drive req_ready_o=1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-026 On acceptance, SHALL latch rw, addr and len.
REQ-027 If len is 0 or greater than 32, SHALL perform no bus activity and pulse done_o with err_o=11 the next cycle.
REQ-028 Transaction flow: START -> ADDR (write DPR {addr,rw}, command WRITE) -> data phase -> STOP -> DONE.
REQ-029 Write data phase: SHALL assert wr_ready_o for one byte at a time; stall until wr_valid_i; on handshake, write DPR, then command step WRITE.
REQ-030 Write data phase: SHALL repeat the per-byte sequence len times.
REQ-031 Read data phase: SHALL issue READ_ACK for bytes 1..len-1 and READ_NAK for byte len.
REQ-032 Read data phase: after each read command step, SHALL read DPR and pulse rd_valid_o for 1 cycle with rd_data_o equal to the captured byte.
REQ-033 If NAK is seen in ADDR or a write byte, SHALL abort the remaining bytes, issue STOP, and report err_o=01.
REQ-034 If AL or ERR is seen at any step, SHALL skip STOP and go directly to DONE with err_o=10 or 11 respectively.
REQ-035 DONE: SHALL pulse done_o for exactly 1 cycle with err_o valid in the same cycle, then return to IDLE.
REQ-036 Byte counter: SHALL be 6 bits, decrement per byte, and never wrap; the data phase ends when it reaches 0.
REQ-037 An irq_i already high when a command step begins SHALL NOT complete that step; the step waits for irq_i following the CMDR write ack.
REQ-038 Sequencer-to-CMDR latency: the CMDR write SHALL issue within 2 cycles of entering a command state.

Reset
REQ-039 On rst_n_i=0, SHALL immediately drive cyc_o, stb_o, we_o, req_ready_o, wr_ready_o, rd_valid_o and done_o to 0; adr_o, dat_o, rd_data_o to 0; err_o to 00.
REQ-040 On rst_n_i=0, SHALL clear all counters; FSM returns to EN.
REQ-041 Reset mid-Wishbone-cycle SHALL drop cyc_o asynchronously; after release, SHALL restart INIT with no stale request or data retained.

Verification
REQ-042 Reset release with BUS_ID=5 -> WB trace: W CSR 0xC0, W DPR 0x05, W CMDR 0x06, R CMDR; then req_ready_o=1.
REQ-043 Write addr 0x22, len 32, data 0..31 -> DPR writes 0x44, 0x00..0x1F; I2C slave sees 32 bytes; done_o with err_o=00.
REQ-044 Read addr 0x22, len 32, slave returns 100..131 -> 31 READ_ACK then 1 READ_NAK; 32 rd_valid_o pulses of 100..131 in order.
REQ-045 Slave NAKs address 0x22 -> no data bytes; STOP issued; err_o=01.
REQ-046 Slave NAKs the 3rd write byte -> no 4th byte; STOP issued; err_o=01.
REQ-047 Request with len 0 -> no Wishbone activity; done_o next cycle with err_o=11.
REQ-048 Reset asserted while waiting on irq_i during a write -> outputs 0 immediately; INIT sequence repeats after release.

Source files
------------

// File: rtl/iicmb_wb_sequencer.sv
// Wishbone master sequencer for the IICMB I2C controller: brings the core up,
// then turns byte-stream read/write requests into IICMB register/command traffic.
module iicmb_wb_sequencer #(
   parameter int unsigned BUS_ID        = 0,
   parameter int unsigned WB_ADDR_WIDTH = 2,
   parameter int unsigned WB_DATA_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_rw_i,
   input  logic [6:0]               req_addr_i,
   input  logic [5:0]               req_len_i,
   input  logic                     wr_valid_i,
   output logic                     wr_ready_o,
   input  logic [7:0]               wr_data_i,
   output logic                     rd_valid_o,
   output logic [7:0]               rd_data_o,
   output logic                     done_o,
   output logic [1:0]               err_o,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   input  logic                     ack_i,
   input  logic                     irq_i
);

   localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
   localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
   localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

   localparam logic [7:0] CMD_WRITE    = 8'h01;
   localparam logic [7:0] CMD_READ_ACK = 8'h02;
   localparam logic [7:0] CMD_READ_NAK = 8'h03;
   localparam logic [7:0] CMD_START    = 8'h04;
   localparam logic [7:0] CMD_STOP     = 8'h05;
   localparam logic [7:0] CMD_SET_BUS  = 8'h06;

   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_NAK  = 2'b01;
   localparam logic [1:0] ERR_AL   = 2'b10;
   localparam logic [1:0] ERR_FAIL = 2'b11;

   typedef enum logic [3:0] {
      S_EN, S_SB_DPR, S_SB_CMD, S_IDLE, S_START, S_ADDR_DPR, S_ADDR_CMD,
      S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_RD_OUT,
      S_STOP, S_DONE, S_ERR_HALT
   } state_e;

   // Command step: write CMDR, wait for irq, read CMDR back for status.
   typedef enum logic [1:0] {PH_WR, PH_IRQ, PH_RD} phase_e;

   state_e                     state_q, state_d;
   phase_e                     ph_q, ph_d;
   logic                       cyc_q, cyc_d;
   logic                       we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;
   logic                       rw_q, rw_d;
   logic [6:0]                 addr_q, addr_d;
   logic [5:0]                 cnt_q, cnt_d;
   logic [7:0]                 wbyte_q, wbyte_d;
   logic [7:0]                 rd_data_q, rd_data_d;
   logic [1:0]                 err_q, err_d;

   logic       acc_done, cmd_state, cmd_fin;
   logic       st_nak, st_al, st_err, fatal;
   logic [1:0] fatal_code;
   logic [5:0] cnt_dec;
   logic [7:0] cmd_code;

   assign acc_done   = cyc_q & ack_i;
   assign cmd_state  = state_q inside {S_SB_CMD, S_START, S_ADDR_CMD, S_WR_CMD, S_RD_CMD, S_STOP};
   assign cmd_fin    = cmd_state && (ph_q == PH_RD) && acc_done;
   assign st_nak     = dat_i[6];
   assign st_al      = dat_i[5];
   assign st_err     = dat_i[4];
   assign fatal      = st_al | st_err;
   assign fatal_code = st_err ? ERR_FAIL : ERR_AL;
   assign cnt_dec    = (cnt_q != 6'd0) ? cnt_q - 6'd1 : 6'd0;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_EN;
         ph_q      <= PH_WR;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
         wbyte_q   <= '0;
         rd_data_q <= '0;
         err_q     <= ERR_OK;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         wbyte_q   <= wbyte_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
      end
   end

   // NOTE: every _d signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      wbyte_d   = wbyte_q;
      rd_data_d = rd_data_q;
      err_d     = err_q;

      if (cmd_state) begin
         if (ph_q == PH_WR && acc_done) ph_d = PH_IRQ;
         else if (ph_q == PH_IRQ && irq_i) ph_d = PH_RD;
      end

      case (state_q)
         S_EN:     if (acc_done) state_d = S_SB_DPR;
         S_SB_DPR: if (acc_done) state_d = S_SB_CMD;
         S_SB_CMD: if (cmd_fin) begin
            if (fatal) begin
               state_d = S_ERR_HALT;
               err_d   = ERR_FAIL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: if (req_valid_i) begin
            rw_d   = req_rw_i;
            addr_d = req_addr_i;
            cnt_d  = req_len_i;
            if (req_len_i == 6'd0 || req_len_i > 6'd32) begin
               err_d   = ERR_FAIL;
               state_d = S_DONE;
            end else begin
               err_d   = ERR_OK;
               state_d = S_START;
            end
         end
         S_START: if (cmd_fin) begin
            if (fatal) begin
               err_d   = fatal_code;
               state_d = S_DONE;
            end else begin
               state_d = S_ADDR_DPR;
            end
         end
         S_ADDR_DPR: if (acc_done) state_d = S_ADDR_CMD;
         S_ADDR_CMD: if (cmd_fin) begin
            if (fatal) begin
               err_d   = fatal_code;
               state_d = S_DONE;
            end else if (st_nak) begin
               err_d   = ERR_NAK;
               state_d = S_STOP;
            end else begin
               state_d = rw_q ? S_RD_CMD : S_WR_WAIT;
            end
         end
         S_WR_WAIT: if (wr_valid_i) begin
            wbyte_d = wr_data_i;
            state_d = S_WR_DPR;
         end
         S_WR_DPR: if (acc_done) state_d = S_WR_CMD;
         S_WR_CMD: if (cmd_fin) begin
            if (fatal) begin
               err_d   = fatal_code;
               state_d = S_DONE;
            end else if (st_nak) begin
               err_d   = ERR_NAK;
               state_d = S_STOP;
            end else begin
               cnt_d   = cnt_dec;
               state_d = (cnt_q <= 6'd1) ? S_STOP : S_WR_WAIT;
            end
         end
         S_RD_CMD: if (cmd_fin) begin
            if (fatal) begin
               err_d   = fatal_code;
               state_d = S_DONE;
            end else begin
               state_d = S_RD_DPR;
            end
         end
         S_RD_DPR: if (acc_done) begin
            rd_data_d = dat_i[7:0];
            state_d   = S_RD_OUT;
         end
         S_RD_OUT: begin
            cnt_d   = cnt_dec;
            state_d = (cnt_q <= 6'd1) ? S_STOP : S_RD_CMD;
         end
         S_STOP: if (cmd_fin) begin
            if (fatal) err_d = fatal_code;
            state_d = S_DONE;
         end
         S_DONE:     state_d = S_IDLE;
         S_ERR_HALT: state_d = S_ERR_HALT;
         default:    state_d = S_EN;
      endcase

      if (state_d != state_q) ph_d = PH_WR;
   end

   // Bus requests are registered; a new access can only start once cyc has
   // dropped, which yields the mandatory idle cycle between accesses.
   always_comb begin
      cmd_code = 8'h00;
      case (state_q)
         S_SB_CMD:             cmd_code = CMD_SET_BUS;
         S_START:              cmd_code = CMD_START;
         S_ADDR_CMD, S_WR_CMD: cmd_code = CMD_WRITE;
         S_RD_CMD:             cmd_code = (cnt_q == 6'd1) ? CMD_READ_NAK : CMD_READ_ACK;
         S_STOP:               cmd_code = CMD_STOP;
         default:              cmd_code = 8'h00;
      endcase

      cyc_d = cyc_q;
      we_d  = we_q;
      adr_d = adr_q;
      dat_d = dat_q;

      if (acc_done) begin
         cyc_d = 1'b0;
         we_d  = 1'b0;
      end else if (!cyc_q) begin
         case (state_q)
            S_EN: begin
               cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_CSR; dat_d = WB_DATA_WIDTH'(8'hC0);
            end
            S_SB_DPR: begin
               cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_DPR; dat_d = WB_DATA_WIDTH'(BUS_ID);
            end
            S_ADDR_DPR: begin
               cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_DPR; dat_d = WB_DATA_WIDTH'({addr_q, rw_q});
            end
            S_WR_DPR: begin
               cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_DPR; dat_d = WB_DATA_WIDTH'(wbyte_q);
            end
            S_RD_DPR: begin
               cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_DPR; dat_d = '0;
            end
            default: if (cmd_state) begin
               // irq is only looked at after the CMDR write has been acknowledged.
               if (ph_q == PH_WR) begin
                  cyc_d = 1'b1; we_d = 1'b1; adr_d = ADR_CMDR; dat_d = WB_DATA_WIDTH'(cmd_code);
               end else if (ph_q == PH_IRQ && irq_i) begin
                  cyc_d = 1'b1; we_d = 1'b0; adr_d = ADR_CMDR; dat_d = '0;
               end
            end
         endcase
      end
   end

   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
   assign req_ready_o = (state_q == S_IDLE);
   assign wr_ready_o  = (state_q == S_WR_WAIT);
   assign rd_valid_o  = (state_q == S_RD_OUT);
   assign rd_data_o   = rd_data_q;
   assign done_o      = (state_q == S_DONE);
   assign err_o       = err_q;

endmodule
